// File: rtl/simon_pkg.sv
// Shared definitions for the Simon playback slice: colour codes, FSM states
// and the colour-to-LED decode used wherever a step is shown.
package simon_pkg;

    localparam logic [1:0] COLOR_RED    = 2'd0;
    localparam logic [1:0] COLOR_GREEN  = 2'd1;
    localparam logic [1:0] COLOR_BLUE   = 2'd2;
    localparam logic [1:0] COLOR_YELLOW = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_ON,
        ST_GAP,
        ST_FIN
    } state_t;

    // Bit n of the LED bus corresponds to colour code n.
    function automatic logic [3:0] color_onehot(input logic [1:0] color);
        logic [3:0] result;
        result = 4'b0000;
        unique case (color)
            COLOR_RED:    result = 4'b0001;
            COLOR_GREEN:  result = 4'b0010;
            COLOR_BLUE:   result = 4'b0100;
            COLOR_YELLOW: result = 4'b1000;
            default:      result = 4'b0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern store: one 2-bit colour per step. Writes land on the clock edge,
// reads are combinational so the sequencer sees the addressed step at once.
// Contents are deliberately not reset; the game always writes before playing.
module simon_pattern_mem #(
    parameter  int MAX_LEN = 16,
    localparam int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_color,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_color
);

    logic [1:0] mem [MAX_LEN];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_color;
        end
    end

    assign rd_color = mem[rd_addr];

endmodule

// File: rtl/simon_playback_ctrl.sv
// Simon playback sequencer: after a start request it shows each stored step
// on the LEDs for ON_TICKS ticks, separated by GAP_TICKS dark ticks, with a
// leading gap before the first step. Time is counted in rate-divider ticks.
module simon_playback_ctrl
    import simon_pkg::*;
#(
    parameter  int MAX_LEN   = 16,
    parameter  int ON_TICKS  = 1,
    parameter  int GAP_TICKS = 1,
    localparam int AW        = $clog2(MAX_LEN),
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          tick,
    input  logic          start,
    input  logic          abort,
    input  logic [LW-1:0] length,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_color,
    output logic [3:0]    led,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_index
);

    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [7:0]    ON_LOAD  = 8'(ON_TICKS);
    localparam logic [7:0]    GAP_LOAD = 8'(GAP_TICKS);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] idx_d;
    logic [3:0]    led_d;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_color;
    logic [LW-1:0] len_clamped;
    logic          last_step;

    assign len_clamped = (length > LEN_MAX) ? LEN_MAX : length;

    // In GAP the next step is about to be shown, so look one entry ahead.
    assign rd_addr   = (state_q == ST_GAP) ? cur_index + 1'b1 : cur_index;
    assign last_step = (LW'(cur_index) + LW'(1)) >= len_q;

    // The pattern cannot change while a playback is in progress.
    simon_pattern_mem #(
        .MAX_LEN (MAX_LEN)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_en && !busy),
        .wr_addr  (wr_addr),
        .wr_color (wr_color),
        .rd_addr  (rd_addr),
        .rd_color (rd_color)
    );

    // Register state, counters and all outputs; busy/done follow the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            cur_index <= '0;
            led       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            cur_index <= idx_d;
            led       <= led_d;
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_FIN);
        end
    end

    // Next-state logic: abort wins over a tick, and a phase ends on the tick that empties the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = cur_index;
        led_d   = led;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d = len_clamped;
                    idx_d = '0;
                    led_d = '0;
                    if (len_clamped == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LEAD;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            ST_LEAD, ST_ON, ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        case (state_q)
                            ST_LEAD: begin
                                state_d = ST_ON;
                                cnt_d   = ON_LOAD;
                                led_d   = color_onehot(rd_color);
                            end
                            ST_ON: begin
                                state_d = ST_GAP;
                                cnt_d   = GAP_LOAD;
                                led_d   = '0;
                            end
                            default: begin
                                if (last_step) begin
                                    state_d = ST_FIN;
                                end else begin
                                    state_d = ST_ON;
                                    idx_d   = rd_addr;
                                    cnt_d   = ON_LOAD;
                                    led_d   = color_onehot(rd_color);
                                end
                            end
                        endcase
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Directed bench for simon_playback_ctrl: each start pushes the expected
// per-tick LED/busy/done/index trace into a queue, which is popped on every
// tick edge and compared; between ticks the outputs must hold steady.
module tb_simon_playback_ctrl;

    localparam int MAX_LEN   = 16;
    localparam int ON_TICKS  = 2;
    localparam int GAP_TICKS = 1;
    localparam int AW        = 4;
    localparam int LW        = 5;

    typedef struct packed {
        logic [3:0]    led;
        logic          busy;
        logic          done;
        logic [AW-1:0] idx;
    } exp_t;

    logic          clk      = 1'b0;
    logic          resetn   = 1'b0;
    logic          tick     = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [LW-1:0] length   = '0;
    logic          wr_en    = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [1:0]    wr_color = '0;
    logic [3:0]    led;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_index;

    exp_t       scoreQ[$];
    logic [1:0] patModel [MAX_LEN];
    int         vectors     = 0;
    int         miscompares = 0;
    int         phase       = 0;
    logic       lastTick    = 1'b0;

    simon_playback_ctrl #(
        .MAX_LEN   (MAX_LEN),
        .ON_TICKS  (ON_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tick      (tick),
        .start     (start),
        .abort     (abort),
        .length    (length),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_color  (wr_color),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .cur_index (cur_index)
    );

    // 100 MHz simulation clock.
    initial begin
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] ledFor(input logic [1:0] c);
        case (c)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic exp_t mk(input logic [3:0] l, input logic b, input logic d, input int i);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.done = d;
        e.idx  = AW'(i);
        return e;
    endfunction

    // One clock: tick is high every fourth clock; single-cycle requests drop after the edge.
    task automatic stepClk();
        tick     = (phase == 3);
        lastTick = tick;
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        start = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic alignTo(input int p);
        while (phase != p) stepClk();
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        exp_t obs;
        obs = {led, busy, done, cur_index};
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("[TB] FAIL %s observed led=%b busy=%b done=%b idx=%0d expected led=%b busy=%b done=%b idx=%0d",
                   tag, obs.led, obs.busy, obs.done, obs.idx, e.led, e.busy, e.done, e.idx);
        end
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] l, input logic b, input logic d);
        vectors++;
        assert ({led, busy, done} === {l, b, d}) else begin
            miscompares++;
            $error("[TB] FAIL %s observed led=%b busy=%b done=%b expected led=%b busy=%b done=%b",
                   tag, led, busy, done, l, b, d);
        end
    endtask

    task automatic writeStep(input int addr, input logic [1:0] color);
        wr_en    = 1'b1;
        wr_addr  = AW'(addr);
        wr_color = color;
        patModel[addr] = color;
        stepClk();
    endtask

    // Issue a start and queue the expected output after every following tick.
    task automatic applyStimulus(input int len);
        int n;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        length = LW'(len);
        start  = 1'b1;
        for (int k = 0; k < GAP_TICKS - 1; k++) scoreQ.push_back(mk(4'b0000, 1'b1, 1'b0, 0));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < ON_TICKS; k++)  scoreQ.push_back(mk(ledFor(patModel[i]), 1'b1, 1'b0, i));
            for (int k = 0; k < GAP_TICKS; k++) scoreQ.push_back(mk(4'b0000, 1'b1, 1'b0, i));
        end
        scoreQ.push_back(mk(4'b0000, 1'b1, 1'b1, n - 1));
        stepClk();
        checkOutput("start_accept", mk(4'b0000, 1'b1, 1'b0, 0));
    endtask

    // Follow the playback; maxTicks > 0 stops early after that many ticks.
    task automatic runPlayback(input string tag, input int budget, input int maxTicks);
        exp_t cur;
        int   popped;
        popped = 0;
        cur    = mk(4'b0000, 1'b1, 1'b0, 0);
        for (int c = 0; c < budget; c++) begin
            if (scoreQ.size() == 0 || (maxTicks > 0 && popped == maxTicks)) break;
            stepClk();
            if (lastTick) begin
                cur = scoreQ.pop_front();
                popped++;
            end
            checkOutput(tag, cur);
        end
        vectors++;
        assert (scoreQ.size() == 0 || (maxTicks > 0 && popped == maxTicks)) else begin
            miscompares++;
            $error("[TB] FAIL %s_timeout observed %0d ticks pending expected 0", tag, scoreQ.size());
            scoreQ.delete();
        end
        if (maxTicks <= 0) begin
            stepClk();
            checkFlags({tag, "_idle"}, 4'b0000, 1'b0, 1'b0);
        end
    endtask

    // Directed sequence covering the playback, abort, clamp and reset behaviour.
    initial begin
        logic doneSeen;

        $display("[TB] reset");
        stepClk();
        stepClk();
        checkOutput("reset", mk(4'b0000, 1'b0, 1'b0, 0));
        resetn = 1'b1;

        writeStep(0, 2'd3);
        writeStep(1, 2'd0);
        writeStep(2, 2'd2);

        $display("[TB] three-step playback, start coincident with a tick");
        alignTo(3);
        applyStimulus(3);
        runPlayback("play3", 200, 0);

        $display("[TB] zero-length playback");
        alignTo(0);
        length = '0;
        start  = 1'b1;
        stepClk();
        checkFlags("zero_len_start", 4'b0000, 1'b1, 1'b1);
        stepClk();
        checkFlags("zero_len_after", 4'b0000, 1'b0, 1'b0);

        $display("[TB] start and write during playback");
        alignTo(0);
        applyStimulus(2);
        length   = LW'(1);
        start    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = '0;
        wr_color = 2'd1;
        stepClk();
        checkOutput("busy_reqs_ignored", mk(4'b0000, 1'b1, 1'b0, 0));
        runPlayback("busy_reqs", 200, 0);
        applyStimulus(1);
        runPlayback("mem_kept", 100, 0);

        $display("[TB] abort in second ON phase");
        alignTo(0);
        applyStimulus(3);
        runPlayback("abort_run", 100, 4);
        abort = 1'b1;
        stepClk();
        checkFlags("abort", 4'b0000, 1'b0, 1'b0);
        scoreQ.delete();
        doneSeen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            stepClk();
            doneSeen = doneSeen | done;
        end
        vectors++;
        assert (doneSeen === 1'b0) else begin
            miscompares++;
            $error("[TB] FAIL abort_no_done observed %b expected 0", doneSeen);
        end
        applyStimulus(1);
        runPlayback("replay", 100, 0);

        $display("[TB] over-long length clamps to MAX_LEN");
        for (int i = 0; i < MAX_LEN; i++) writeStep(i, 2'((i * 3 + 1) % 4));
        applyStimulus(20);
        runPlayback("clamp16", 400, 0);

        $display("[TB] asynchronous reset mid-ON");
        alignTo(0);
        applyStimulus(3);
        runPlayback("rst_run", 100, 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("reset_async", mk(4'b0000, 1'b0, 1'b0, 0));
        scoreQ.delete();
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            stepClk();
            checkFlags("post_reset_idle", 4'b0000, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simon_playback_ctrl.md
# simon_playback_ctrl

Playback sequencer for the Simon game. It stores a colour pattern of up to MAX_LEN steps and, on a start request, lights each step's LED for a fixed number of ticks, with a dark gap before and after each step. Its time base is the one-pulse-per-second tick from the board rate divider, so all phase durations are counted in ticks, not clocks. It sits between the game FSM, which writes the pattern and requests playback, and the LED outputs.

## Interface
- MAX_LEN, 16: pattern depth in steps; power of two, at least 2.
- ON_TICKS, 1: ticks each LED stays lit; range 1..255.
- GAP_TICKS, 1: dark ticks before the first step and after every step; range 1..255.
- clk  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle time-base pulse from the rate divider.
- start  input  1  single-cycle playback request.
- abort  input  1  single-cycle cancel request.
- length  input  clog2(MAX_LEN+1)  number of steps to play; sampled on an accepted start.
- wr_en  input  1  pattern write strobe.
- wr_addr  input  clog2(MAX_LEN)  step index to write.
- wr_color  input  2  colour code: 0 red, 1 green, 2 blue, 3 yellow.
- led  output  4  one-hot lit LED, bit n corresponds to colour n; all zero when dark.
- busy  output  1  high while playback is in progress.
- done  output  1  single-cycle pulse when playback completes normally.
- cur_index  output  clog2(MAX_LEN)  index of the step currently playing.

## Operation
- States: IDLE, LEAD, ON, GAP, FIN.
- IDLE
  - start=1 latches length, clamping any value above MAX_LEN to MAX_LEN.
  - Latched length 0 → FIN. Otherwise → LEAD, with cur_index=0 and the tick counter loaded with GAP_TICKS.
- LEAD, ON, GAP
  - Each tick decrements the tick counter.
  - On the tick that brings the counter to 0, the state transitions:
  - LEAD → ON: load ON_TICKS; led = onehot(mem[cur_index]).
  - ON → GAP: load GAP_TICKS; led = 0.
  - GAP → ON if cur_index+1 < latched length: increment cur_index, load ON_TICKS, light the next LED.
  - GAP → FIN when the last step's gap has elapsed.
- FIN: done=1 for exactly one cycle, then → IDLE.
- Ignored or dropped requests
  - start while not in IDLE is ignored.
  - wr_en while busy=1 is dropped, so the stored pattern cannot change during playback.
  - Writes in IDLE update the memory the next cycle.
- Simultaneous events
  - A tick in the same cycle as an accepted start is not counted; counting begins on the next tick.
  - abort in LEAD, ON or GAP → IDLE next cycle, with led=0, busy=0 and no done pulse.
  - abort has priority over a tick in the same cycle.
  - abort in IDLE or FIN has no effect.
- Reset (asynchronous, including mid-playback): state=IDLE, led=0, busy=0, done=0, cur_index=0, tick counter=0. Pattern memory contents are not reset.

## Timing
- All outputs are registered.
- start accepted at edge t → busy=1 from t+1.
- An expiring tick sampled at edge t → new led value and cur_index visible from t+1.
- FIN is entered at t+1 after the final gap tick at edge t. done=1 during that cycle, and busy falls to 0 at t+2.
- busy is high in LEAD, ON, GAP and FIN.
- Zero-length playback: start at t → busy=1 and done=1 at t+1 → busy=0 at t+2, with no LED activity.
- Total playback time is GAP_TICKS + N·(ON_TICKS+GAP_TICKS) ticks.
- Memory read is combinational from the registered cur_index. There is no read latency.

## Structure
- Shared package simon_pkg:
  - colour encoding constants;
  - state typedef;
  - onehot-decode function for colour → led.
- One sub-module, simon_pattern_mem: MAX_LEN×2 register file with a synchronous write port and an asynchronous read port. It has no reset.
- Tick counter width is 8 bits.

## Test plan
Bench settings: tick every 4 clocks; ON_TICKS=2, GAP_TICKS=1.
- Write pattern 3,0,2 at addresses 0..2, then start with length=3 → led sequence:
  - 0 for 1 tick;
  - 1000 for 2 ticks, 0 for 1;
  - 0001 for 2, 0 for 1;
  - 0100 for 2, 0 for 1;
  - then one done pulse;
  - busy high for exactly 10 ticks plus the FIN cycle.
- start with length=0 → done=1 one cycle after start; led remains 0; busy low two cycles after start.
- length=20 with MAX_LEN=16 → 16 steps played; cur_index reaches 15 and never wraps.
- abort during the second ON phase → led=0 and busy=0 next cycle; done is never asserted; a later start replays from index 0.
- start asserted during playback, and wr_en to address 0 during playback → both ignored; the memory still holds the old colour after done.
- Assert resetn=0 mid-ON → led, busy and done go to 0 immediately; after release the block stays in IDLE until start.
